// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding and the divide-by-zero quotient helper.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // All-ones quotient reported for a zero divisor, right-aligned to width bits.
  function automatic logic [31:0] div_zero_quot(input int unsigned width);
    return {32{1'b1}} >> (32 - width);
  endfunction

endpackage

// File: rtl/param_adder.sv
// Generic ripple adder with carry-in and carry-out.
// The divider uses it as a subtractor: b = ~subtrahend, cin = 1.
module param_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Widen by one bit so the top bit of the result is the carry-out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIV_ZERO_CHK_EN -- when defined, a zero divisor
// skips the iterations and finishes one cycle after the start with o_div_zero set.
// Without it a zero divisor runs the full loop and o_div_zero stays 0.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
`ifdef SEQ_DIV_ZERO_CHK_EN
  localparam logic [31:0] ZERO_QUOT = div_zero_quot(WIDTH);
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_qd;
  logic             unused_prem_msb;

  // qd_q starts as the dividend and fills with quotient bits from the right;
  // its MSB is the next dividend bit pulled into the partial remainder.
  assign shifted = {prem_q[WIDTH-1:0], qd_q[WIDTH-1]};

  // The partial remainder stays below the divisor between steps, so its top bit is always zero.
  assign unused_prem_msb = prem_q[WIDTH];

  param_adder #(
    .WIDTH(WIDTH + 1)
  ) u_trial_sub (
    .a   (shifted),
    .b   (~{1'b0, divisor_q}),
    .cin (1'b1),
    .sum (diff),
    .cout(no_borrow)
  );

  assign step_rem = no_borrow ? diff : shifted;
  assign step_qd  = {qd_q[WIDTH-2:0], no_borrow};

  // Next-state logic: capture in IDLE, one restoring step per CALC cycle, single DONE cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qd_d       = qd_q;
    divisor_d  = divisor_q;
    prem_d     = prem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d   = CALC;
          qd_d      = i_dividend;
          divisor_d = i_divisor;
          prem_d    = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
        end
      end
      CALC: begin
`ifdef SEQ_DIV_ZERO_CHK_EN
        if (divisor_q == '0) begin
          state_d    = DONE;
          quot_d     = ZERO_QUOT[WIDTH-1:0];
          rem_d      = qd_q;
          done_d     = 1'b1;
          div_zero_d = 1'b1;
        end else
`endif
        begin
          prem_d = step_rem;
          qd_d   = step_qd;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            quot_d  = step_qd;
            rem_d   = step_rem[WIDTH-1:0];
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset discards any division in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      qd_q       <= '0;
      divisor_q  <= '0;
      prem_q     <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qd_q       <= qd_d;
      divisor_q  <= divisor_d;
      prem_q     <= prem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign o_quot     = quot_q;
  assign o_rem      = rem_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases on a 4-bit instance and
// randomized back-to-back divisions on an 8-bit instance, both compared with
// plain integer division. Honours SEQ_DIV_ZERO_CHK_EN when defined.
module tb_seq_div;

`ifdef SEQ_DIV_ZERO_CHK_EN
  localparam bit ZeroChk = 1'b1;
`else
  localparam bit ZeroChk = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstN;

  logic       start4;
  logic [3:0] dividend4, divisor4, quot4, rem4;
  logic       busy4, done4, divZero4;

  logic       start8;
  logic [7:0] dividend8, divisor8, quot8, rem8;
  logic       busy8, done8, divZero8;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  seq_div #(.WIDTH(4)) dut4 (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_start   (start4),
    .i_dividend(dividend4),
    .i_divisor (divisor4),
    .o_quot    (quot4),
    .o_rem     (rem4),
    .o_busy    (busy4),
    .o_done    (done4),
    .o_div_zero(divZero4)
  );

  seq_div #(.WIDTH(8)) dut8 (
    .i_clk     (clk),
    .i_rst_n   (rstN),
    .i_start   (start8),
    .i_dividend(dividend8),
    .i_divisor (divisor8),
    .o_quot    (quot8),
    .o_rem     (rem8),
    .o_busy    (busy8),
    .o_done    (done8),
    .o_div_zero(divZero8)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One 4-bit division; intrudeAt > 0 raises i_start with 7/2 on that edge after t0.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int intrudeAt, input string tag);
    logic [3:0] expQ, expR, gotQ, gotR;
    logic       expZ, gotZ;
    int         expK, nDone, doneAt;
    bit         busyOk;
    expQ = (b == 4'd0) ? 4'hF : a / b;
    expR = (b == 4'd0) ? a : a % b;
    expZ = ZeroChk && (b == 4'd0);
    expK = expZ ? 1 : 4;
    dividend4 = a;
    divisor4  = b;
    start4    = 1'b1;
    tick;
    start4    = 1'b0;
    dividend4 = 4'($urandom);
    divisor4  = 4'($urandom);
    checkOutput({tag, " busy@t0"}, 32'(busy4), 32'd1);
    nDone  = 0;
    doneAt = -1;
    gotQ   = '0;
    gotR   = '0;
    gotZ   = 1'b0;
    busyOk = 1'b1;
    for (int k = 1; k <= expK + 3; k++) begin
      if (k == intrudeAt) begin
        start4    = 1'b1;
        dividend4 = 4'd7;
        divisor4  = 4'd2;
      end
      tick;
      start4 = 1'b0;
      if (done4) begin
        nDone++;
        doneAt = k;
        gotQ   = quot4;
        gotR   = rem4;
        gotZ   = divZero4;
      end
      if (busy4 !== (k <= expK)) busyOk = 1'b0;
    end
    checkOutput({tag, " done count"}, 32'(nDone), 32'd1);
    checkOutput({tag, " done edge"}, 32'(doneAt), 32'(expK));
    checkOutput({tag, " quot"}, 32'(gotQ), 32'(expQ));
    checkOutput({tag, " rem"}, 32'(gotR), 32'(expR));
    checkOutput({tag, " div_zero"}, 32'(gotZ), 32'(expZ));
    checkOutput({tag, " busy window"}, 32'(busyOk), 32'd1);
    checkOutput({tag, " quot held"}, 32'(quot4), 32'(expQ));
    checkOutput({tag, " rem held"}, 32'(rem4), 32'(expR));
  endtask

  initial begin
    logic [7:0] a8, b8, expQ8, expR8;
    logic       expZ8;
    int         lat, doneAt, nDone;

    rstN      = 1'b0;
    start4    = 1'b0;
    dividend4 = '0;
    divisor4  = '0;
    start8    = 1'b0;
    dividend8 = '0;
    divisor8  = '0;
    #3;
    checkOutput("reset dut4 outputs", 32'({quot4, rem4, busy4, done4, divZero4}), 32'd0);
    checkOutput("reset dut8 outputs", 32'({quot8, rem8, busy8, done8, divZero8}), 32'd0);
    tick;
    tick;
    rstN = 1'b1;
    tick;

    $display("[TB] directed 4-bit cases");
    applyStimulus(4'd13, 4'd3, 0, "13/3");
    applyStimulus(4'd15, 4'd1, 0, "15/1");
    applyStimulus(4'd5, 4'd7, 0, "5/7");
    applyStimulus(4'd0, 4'd9, 0, "0/9");
    applyStimulus(4'd15, 4'd15, 0, "15/15");
    applyStimulus(4'd9, 4'd0, 0, "9/0");
    applyStimulus(4'd13, 4'd3, 2, "13/3 start while busy");

    $display("[TB] reset during CALC");
    dividend4 = 4'd13;
    divisor4  = 4'd3;
    start4    = 1'b1;
    tick;
    start4 = 1'b0;
    tick;
    tick;
    rstN = 1'b0;
    #1;
    checkOutput("mid-calc reset outputs", 32'({quot4, rem4, busy4, done4, divZero4}), 32'd0);
    nDone = 0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (done4) nDone++;
    end
    rstN = 1'b1;
    checkOutput("no done during reset", 32'(nDone), 32'd0);
    applyStimulus(4'd11, 4'd4, 0, "11/4 after reset");

    $display("[TB] random back-to-back 8-bit divisions");
    start8 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      dividend8 = a8;
      divisor8  = b8;
      tick;
      expQ8 = (b8 == 8'd0) ? 8'hFF : a8 / b8;
      expR8 = (b8 == 8'd0) ? a8 : a8 % b8;
      expZ8 = ZeroChk && (b8 == 8'd0);
      lat   = expZ8 ? 1 : 8;
      doneAt = -1;
      for (int k = 1; k <= 12; k++) begin
        dividend8 = 8'($urandom);
        divisor8  = 8'($urandom);
        tick;
        if (done8) begin
          doneAt = k;
          break;
        end
      end
      checkOutput("rnd latency", 32'(doneAt), 32'(lat));
      checkOutput("rnd quot", 32'(quot8), 32'(expQ8));
      checkOutput("rnd rem", 32'(rem8), 32'(expR8));
      checkOutput("rnd div_zero", 32'(divZero8), 32'(expZ8));
      dividend8 = 8'($urandom);
      divisor8  = 8'($urandom);
      tick;
    end
    start8 = 1'b0;
    tick;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
